// File: rtl/smaesh_prng_reseed_ctrl.sv
// Reseed controller for the SMAesH PRNG: captures a seed on the arbiter's
// request, loads it into the PRNG core, discards a fixed number of warm-up
// steps, then gates PRNG advancement with a valid/ready handshake.
module smaesh_prng_reseed_ctrl #(
  parameter int unsigned SEED_W        = 80,
  parameter int unsigned WARMUP_CYCLES = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_reseed,
  input  logic [SEED_W-1:0] in_seed,
  output logic              prng_busy,
  output logic              prng_seeded,
  output logic              core_seed_load,
  output logic [SEED_W-1:0] core_seed,
  output logic              core_step,
  output logic              rnd_valid,
  input  logic              rnd_ready
);

  // Counter only has to hold WARMUP_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int unsigned CNT_INIT = (WARMUP_CYCLES > 0) ? (WARMUP_CYCLES - 1) : 0;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WARMUP   = 2'd2,
    ST_READY    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic              busy_q, busy_d;
  logic              seeded_q, seeded_d;
  logic              load_q, load_d;

  // Next-state, counter, seed register and next registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    case (state_q)
      ST_UNSEEDED, ST_READY: begin
        if (start_reseed) begin
          state_d = ST_LOAD;
          seed_d  = in_seed;
        end
      end
      ST_LOAD: begin
        // Seed residue is wiped as soon as the core has taken it.
        seed_d = '0;
        if (WARMUP_CYCLES > 0) begin
          state_d = ST_WARMUP;
          cnt_d   = CNT_W'(CNT_INIT);
        end else begin
          state_d = ST_READY;
        end
      end
      ST_WARMUP: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_UNSEEDED;
      end
    endcase
    // Registered status follows the state being entered, so busy rises
    // the cycle after the request and stays glitch-free across LOAD->WARMUP.
    busy_d   = (state_d == ST_LOAD) || (state_d == ST_WARMUP);
    seeded_d = (state_d == ST_READY);
    load_d   = (state_d == ST_LOAD);
  end

  // State, counter, seed and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_UNSEEDED;
      cnt_q    <= '0;
      seed_q   <= '0;
      busy_q   <= 1'b0;
      seeded_q <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seed_q   <= seed_d;
      busy_q   <= busy_d;
      seeded_q <= seeded_d;
      load_q   <= load_d;
    end
  end

  assign prng_busy      = busy_q;
  assign prng_seeded    = seeded_q;
  assign core_seed_load = load_q;
  // Seed register is only non-zero while in LOAD.
  assign core_seed      = seed_q;

  assign rnd_valid = (state_q == ST_READY);
  assign core_step = (state_q == ST_WARMUP) || (rnd_valid && rnd_ready);

endmodule

// File: doc/smaesh_prng_reseed_ctrl.md
Name: smaesh_prng_reseed_ctrl

Overview:
- Controller directly downstream of the SMAesH arbiter's reseed request.
- Captures the input seed when the arbiter asserts prng_start_reseed, loads it into the PRNG core, then runs a fixed warm-up so that early output is discarded.
- Reports prng_busy and prng_seeded back to the arbiter.
- Afterwards gates PRNG advancement with a valid/ready randomness handshake toward the AES core and the key-schedule unit (KSU).

Parameters:
- SEED_W, 80, width of the seed word and of the PRNG core seed input.
- WARMUP_CYCLES, 128, number of PRNG steps discarded after each seed load; range 0..1023.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_reseed  in  1  reseed request; driven by the arbiter's prng_start_reseed.
- in_seed  in  SEED_W  seed word; stable while start_reseed is high.
- prng_busy  out  1  reseed in progress; to the arbiter.
- prng_seeded  out  1  PRNG holds a valid, warmed-up seed; to the arbiter.
- core_seed_load  out  1  one-cycle pulse; the PRNG core loads core_seed.
- core_seed  out  SEED_W  seed presented to the PRNG core.
- core_step  out  1  PRNG core advances one step this cycle.
- rnd_valid  out  1  PRNG output is usable by consumers.
- rnd_ready  in  1  consumer takes one PRNG output this cycle.

Behaviour:
- Reset: synchronous, active-high. It forces state UNSEEDED and clears the seed register and warm-up counter to 0. All outputs are 0 on the cycle after rst is sampled high.
- State IDLE_UNSEEDED:
  - busy=0, seeded=0.
  - start_reseed=1: capture in_seed into the seed register, then go to LOAD.
- State LOAD (1 cycle):
  - busy=1, seeded=0.
  - core_seed_load=1; core_seed = seed register.
  - Next: WARMUP if WARMUP_CYCLES>0, else READY.
  - The seed register is cleared to 0 on exit from LOAD; no seed residue is retained.
- State WARMUP:
  - busy=1, seeded=0, core_step=1 every cycle.
  - The counter loads WARMUP_CYCLES-1 on entry and decrements each cycle.
  - At counter==0, go to READY. Exactly WARMUP_CYCLES core_step pulses are issued.
- State READY:
  - busy=0, seeded=1.
  - rnd_valid=1; core_step = rnd_valid & rnd_ready.
  - start_reseed=1: capture in_seed and go to LOAD; seeded drops to 0 on the next cycle together with busy rising.
  - A simultaneous rnd_ready in that cycle is still honoured (core_step=1).
- Arbiter-timing contract:
  - prng_busy rises exactly one cycle after the start_reseed cycle. The arbiter's in_seed_ready is derived from that busy rising edge.
  - Busy then stays high continuously for 1+WARMUP_CYCLES cycles.
  - There is no busy glitch between LOAD and WARMUP.
- start_reseed while busy (LOAD or WARMUP): ignored; the seed register is not overwritten and the counter is not restarted.
- Outside LOAD, core_seed is driven to 0.
- rnd_valid = seeded & ~busy. rnd_ready while not valid has no effect.
- core_step is never high in UNSEEDED or LOAD.
- All outputs are registered except core_step and rnd_valid, which are combinational from state and rnd_ready.
- The counter width is the minimum needed for WARMUP_CYCLES-1. No wrap is possible because the counter is reloaded on every WARMUP entry.
- Reset asserted mid-WARMUP returns to UNSEEDED with seeded=0. No partial seed is kept.

Test Plan:
- Reset then idle 10 cycles -> busy=0, seeded=0, rnd_valid=0, core_step=0 throughout.
- WARMUP_CYCLES=4, start_reseed=1 with in_seed=0x0123456789ABCDEF0011 for one cycle at T:
  - core_seed_load=1 with that seed at T+1.
  - core_step=1 at T+2..T+5.
  - busy=1 at T+1..T+5; seeded=1 and rnd_valid=1 from T+6.
- In READY, rnd_ready pattern 1,0,1,1 -> core_step follows 1,0,1,1.
  - Then start_reseed with seed 0xFFFF...FF -> seeded=0 next cycle and a new 5-cycle busy window.
- start_reseed re-pulsed with a different seed during WARMUP -> ignored. Busy length is unchanged, and only the first seed appears on core_seed.
- WARMUP_CYCLES=0 -> LOAD for 1 cycle, then READY immediately. Busy is high for exactly 1 cycle and there are zero warm-up steps.
- rst=1 at the 2nd WARMUP cycle -> next cycle all outputs are 0 and state is UNSEEDED.
  - A subsequent reseed completes normally with the full warm-up count.
